// File: rtl/updown_ctrl_pkg.sv
// Shared encodings and defaults for the up/down counter sequencer.
package updown_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 3;
    localparam int unsigned DEF_PW    = 4;

    typedef enum logic [1:0] {
        MODE_UP_ONCE   = 2'b00,
        MODE_DOWN_ONCE = 2'b01,
        MODE_BOUNCE    = 2'b10,
        MODE_RSVD      = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN_UP,
        ST_RUN_DOWN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/updown_counter_core.sv
// WIDTH-bit up/down counter register with synchronous load; dir 0=up, 1=down.
module updown_counter_core
    import updown_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (en)
            q <= dir ? q - WIDTH'(1) : q + WIDTH'(1);
    end

endmodule

// File: rtl/updown_seq_ctrl.sv
// Sequencer driving an up/down counter between latched bounds: single sweeps
// up or down, or bouncing between lo and hi for a programmed number of passes.
module updown_seq_ctrl
    import updown_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned PW    = DEF_PW
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [PW-1:0]    passes,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             m,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e           state, state_n;
    mode_e            mode_r;
    logic [WIDTH-1:0] lo_r, hi_r;
    logic [PW-1:0]    passes_r, pass_cnt, pass_cnt_n;
    logic             m_n, busy_n, done_n, err_n, latch;
    logic             load, en, dir;
    logic [WIDTH-1:0] load_val;
    logic             reject, end_pass, last_pass;

    updown_counter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .dir      (dir),
        .q        (q)
    );

    assign reject    = (lo > hi) || (mode == MODE_RSVD) ||
                       ((mode == MODE_BOUNCE) && (passes == '0));
    assign end_pass  = ((state == ST_RUN_UP) && (q == hi_r)) ||
                       ((state == ST_RUN_DOWN) && (q == lo_r));
    assign last_pass = (mode_r != MODE_BOUNCE) ||
                       ((pass_cnt + PW'(1)) == passes_r) || (lo_r == hi_r);

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= ST_IDLE;
            mode_r   <= MODE_UP_ONCE;
            lo_r     <= '0;
            hi_r     <= '0;
            passes_r <= '0;
            pass_cnt <= '0;
            m        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            pass_cnt <= pass_cnt_n;
            m        <= m_n;
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
            if (latch) begin
                mode_r   <= mode_e'(mode);
                lo_r     <= lo;
                hi_r     <= hi;
                passes_r <= passes;
            end
        end
    end

    always_comb begin
        state_n    = state;
        pass_cnt_n = pass_cnt;
        m_n        = m;
        busy_n     = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        latch      = 1'b0;
        load       = 1'b0;
        load_val   = lo;
        en         = 1'b0;
        dir        = m;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    latch = 1'b1;
                    if (reject) begin
                        err_n = 1'b1;
                    end else begin
                        load       = 1'b1;
                        pass_cnt_n = '0;
                        busy_n     = 1'b1;
                        if (mode == MODE_DOWN_ONCE) begin
                            load_val = hi;
                            m_n      = 1'b1;
                            state_n  = ST_RUN_DOWN;
                        end else begin
                            load_val = lo;
                            m_n      = 1'b0;
                            state_n  = ST_RUN_UP;
                        end
                    end
                end
            end
            ST_RUN_UP, ST_RUN_DOWN: begin
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (!end_pass) begin
                    en     = 1'b1;
                    dir    = (state == ST_RUN_DOWN);
                    busy_n = 1'b1;
                end else begin
                    pass_cnt_n = pass_cnt + PW'(1);
                    if (last_pass) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end else begin
                        // Turn at the bound in the same edge: no repeated value.
                        en      = 1'b1;
                        dir     = (state == ST_RUN_UP);
                        m_n     = ~m;
                        busy_n  = 1'b1;
                        state_n = (state == ST_RUN_UP) ? ST_RUN_DOWN : ST_RUN_UP;
                    end
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Directed bench for updown_seq_ctrl: per-cycle expected outputs go through a scoreboard queue.
module tb_updown_seq_ctrl;

    logic       clk = 1'b0;
    logic       clr, start, stop;
    logic [1:0] mode;
    logic [2:0] lo, hi, q;
    logic [3:0] passes;
    logic       m, busy, done, err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef logic [6:0] exp_t;   // {q[2:0], m, busy, done, err}
    exp_t sb[$];

    updown_seq_ctrl #(.WIDTH(3), .PW(4)) dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .mode   (mode),
        .lo     (lo),
        .hi     (hi),
        .passes (passes),
        .stop   (stop),
        .q      (q),
        .m      (m),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic tick(input string tag, input logic [2:0] eq, input logic em,
                        input logic eb, input logic ed, input logic ee);
        exp_t exp_v, obs;
        sb.push_back({eq, em, eb, ed, ee});
        @(posedge clk);
        #1;
        exp_v = sb.pop_front();
        obs   = {q, m, busy, done, err};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed q=%0d m=%b busy=%b done=%b err=%b, expected q=%0d m=%b busy=%b done=%b err=%b",
                   tag, obs[6:4], obs[3], obs[2], obs[1], obs[0],
                   exp_v[6:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic cmd(input logic [1:0] md, input logic [2:0] l, input logic [2:0] h,
                       input logic [3:0] p);
        start  = 1'b1;
        mode   = md;
        lo     = l;
        hi     = h;
        passes = p;
    endtask

    initial begin
        clr = 1'b1; start = 1'b1; stop = 1'b0;
        mode = 2'b00; lo = 3'd2; hi = 3'd5; passes = 4'd1;
        @(negedge clk);

        // 1: reset dominates start
        tick("reset0", 3'd0, 0, 0, 0, 0);
        tick("reset1", 3'd0, 0, 0, 0, 0);
        clr = 1'b0; start = 1'b0;
        tick("idle", 3'd0, 0, 0, 0, 0);

        // 2: UP_ONCE 2..5; inputs scrambled after start to prove latching
        cmd(2'b00, 3'd2, 3'd5, 4'd0);
        tick("up_q2", 3'd2, 0, 1, 0, 0);
        start = 1'b0; lo = 3'd0; hi = 3'd7;
        for (int i = 3; i <= 5; i++) tick("up_run", 3'(i), 0, 1, 0, 0);
        tick("up_done", 3'd5, 0, 0, 1, 0);
        tick("up_idle", 3'd5, 0, 0, 0, 0);

        // 3: BOUNCE 1..3, passes=2 then passes=3
        cmd(2'b10, 3'd1, 3'd3, 4'd2);
        tick("b2_q1", 3'd1, 0, 1, 0, 0);
        start = 1'b0;
        tick("b2_q2", 3'd2, 0, 1, 0, 0);
        tick("b2_q3", 3'd3, 0, 1, 0, 0);
        tick("b2_q2d", 3'd2, 1, 1, 0, 0);
        tick("b2_q1d", 3'd1, 1, 1, 0, 0);
        tick("b2_done", 3'd1, 1, 0, 1, 0);
        tick("b2_idle", 3'd1, 1, 0, 0, 0);
        cmd(2'b10, 3'd1, 3'd3, 4'd3);
        tick("b3_q1", 3'd1, 0, 1, 0, 0);
        start = 1'b0;
        tick("b3_q2", 3'd2, 0, 1, 0, 0);
        tick("b3_q3", 3'd3, 0, 1, 0, 0);
        tick("b3_q2d", 3'd2, 1, 1, 0, 0);
        tick("b3_q1d", 3'd1, 1, 1, 0, 0);
        tick("b3_q2u", 3'd2, 0, 1, 0, 0);
        tick("b3_q3u", 3'd3, 0, 1, 0, 0);
        tick("b3_done", 3'd3, 0, 0, 1, 0);
        tick("b3_idle", 3'd3, 0, 0, 0, 0);

        // 4: rejected commands
        cmd(2'b00, 3'd6, 3'd2, 4'd1);
        tick("rej_lohi", 3'd3, 0, 0, 0, 1);
        start = 1'b0;
        tick("rej_lohi_end", 3'd3, 0, 0, 0, 0);
        cmd(2'b11, 3'd1, 3'd2, 4'd1);
        tick("rej_mode", 3'd3, 0, 0, 0, 1);
        start = 1'b0;
        tick("rej_mode_end", 3'd3, 0, 0, 0, 0);
        cmd(2'b10, 3'd1, 3'd2, 4'd0);
        tick("rej_pass0", 3'd3, 0, 0, 0, 1);
        start = 1'b0;
        tick("rej_pass0_end", 3'd3, 0, 0, 0, 0);

        // 5: DOWN_ONCE 7..0 aborted at q=4, stop in IDLE is inert, then restart
        cmd(2'b01, 3'd0, 3'd7, 4'd0);
        tick("dn_q7", 3'd7, 1, 1, 0, 0);
        start = 1'b0;
        for (int i = 6; i >= 4; i--) tick("dn_run", 3'(i), 1, 1, 0, 0);
        stop = 1'b1;
        tick("dn_stop", 3'd4, 1, 0, 0, 0);
        tick("stop_idle", 3'd4, 1, 0, 0, 0);
        stop = 1'b0;
        cmd(2'b00, 3'd6, 3'd7, 4'd0);
        tick("rs_q6", 3'd6, 0, 1, 0, 0);
        start = 1'b0;
        tick("rs_q7", 3'd7, 0, 1, 0, 0);
        tick("rs_done", 3'd7, 0, 0, 1, 0);
        tick("rs_idle", 3'd7, 0, 0, 0, 0);

        // stop coinciding with end of pass: stop wins, no done
        cmd(2'b00, 3'd3, 3'd4, 4'd0);
        tick("se_q3", 3'd3, 0, 1, 0, 0);
        start = 1'b0;
        tick("se_q4", 3'd4, 0, 1, 0, 0);
        stop = 1'b1;
        tick("se_stop", 3'd4, 0, 0, 0, 0);
        stop = 1'b0;
        tick("se_idle", 3'd4, 0, 0, 0, 0);

        // 6: lo==hi BOUNCE ends after one pass; start in RUN/DONE ignored
        cmd(2'b10, 3'd5, 3'd5, 4'd4);
        tick("eq_q5", 3'd5, 0, 1, 0, 0);
        cmd(2'b01, 3'd0, 3'd1, 4'd1);
        tick("eq_done", 3'd5, 0, 0, 1, 0);
        start = 1'b0;
        tick("eq_idle", 3'd5, 0, 0, 0, 0);

        // start pulsed mid-run on a longer sweep
        cmd(2'b00, 3'd1, 3'd3, 4'd0);
        tick("sb_q1", 3'd1, 0, 1, 0, 0);
        cmd(2'b01, 3'd0, 3'd7, 4'd0);
        tick("sb_q2", 3'd2, 0, 1, 0, 0);
        start = 1'b0;
        tick("sb_q3", 3'd3, 0, 1, 0, 0);
        tick("sb_done", 3'd3, 0, 0, 1, 0);
        tick("sb_idle", 3'd3, 0, 0, 0, 0);

        // clr mid-run
        cmd(2'b01, 3'd1, 3'd6, 4'd0);
        tick("cl_q6", 3'd6, 1, 1, 0, 0);
        start = 1'b0;
        tick("cl_q5", 3'd5, 1, 1, 0, 0);
        clr = 1'b1;
        tick("cl_reset", 3'd0, 0, 0, 0, 0);
        clr = 1'b0;
        tick("cl_idle", 3'd0, 0, 0, 0, 0);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: observed %0d leftover entries, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
